// File: rtl/modn_serial_checker_pkg.sv
// Shared types and helpers for the modulo-N serial divisibility checker.
//   bit_order_e   : serial bit order (MSB_FIRST = 0, LSB_FIRST = 1)
//   state_e       : checker state (IDLE = nothing accepted yet, ACCUM = accumulating)
//   residue_width : residue width for a given modulus
package modn_pkg;

  typedef enum logic {
    MSB_FIRST = 1'b0,
    LSB_FIRST = 1'b1
  } bit_order_e;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_e;

  // Number of bits needed to hold 0..modulus-1.
  function automatic int unsigned residue_width(input int unsigned modulus);
    return (modulus < 2) ? 1 : $clog2(modulus);
  endfunction

endpackage

// File: rtl/modn_serial_checker_step.sv
// modn_step: one serial step of the running residue, purely combinational.
// Ports:
//   r, w    : current residue and current bit weight (2^i mod MODULUS)
//   b       : incoming bit
//   mode    : bit order used for this step
//   r_next  : updated residue
//   w_next  : updated weight (unchanged in MSB-first mode)
// All sums fit in RW+1 bits and are below 2*MODULUS, so one conditional
// subtract brings them back into range.
module modn_step
  import modn_pkg::*;
#(
  parameter  int unsigned MODULUS = 3,
  localparam int unsigned RW      = residue_width(MODULUS)
) (
  input  logic [RW-1:0] r,
  input  logic [RW-1:0] w,
  input  logic          b,
  input  bit_order_e    mode,
  output logic [RW-1:0] r_next,
  output logic [RW-1:0] w_next
);

  localparam logic [RW:0] MOD_EXT = (RW+1)'(MODULUS);

  logic [RW:0] msb_sum;
  logic [RW:0] lsb_sum;
  logic [RW:0] w_dbl;
  logic [RW:0] r_sum;

  always_comb begin
    msb_sum = {r, b};
    lsb_sum = {1'b0, r} + (b ? {1'b0, w} : '0);
    w_dbl   = {w, 1'b0};
    r_sum   = (mode == MSB_FIRST) ? msb_sum : lsb_sum;
    r_next  = (r_sum >= MOD_EXT) ? RW'(r_sum - MOD_EXT) : RW'(r_sum);
    if (mode == MSB_FIRST) begin
      w_next = w;
    end else begin
      w_next = (w_dbl >= MOD_EXT) ? RW'(w_dbl - MOD_EXT) : RW'(w_dbl);
    end
  end

endmodule

// File: rtl/modn_serial_checker.sv
// modn_serial_checker: streaming divisibility detector for MODULUS.
// Consumes one bit per cycle when bit_valid is high, MSB- or LSB-first, and
// keeps the residue of the number received since the last clear.
// Ports:
//   clk, reset_n : clock (rising edge), asynchronous active-low reset
//   clear        : start a new number; samples mode
//   mode         : 0 = MSB-first, 1 = LSB-first (only sampled with clear)
//   bit_in       : serial data bit, consumed when bit_valid is high
//   res          : accumulated value mod MODULUS == 0
//   res_valid    : at least one bit accepted since clear/reset
//   residue      : accumulated value mod MODULUS
//   bit_count    : saturating count of accepted bits (MODN_BITCOUNT_EN only)
// Build option: define MODN_BITCOUNT_EN to add the bit_count port/counter.
module modn_serial_checker
  import modn_pkg::*;
#(
  parameter  int unsigned MODULUS = 3,
  parameter  int unsigned CNT_W   = 8,
  localparam int unsigned RW      = residue_width(MODULUS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          mode,
  input  logic          bit_in,
  input  logic          bit_valid,
  output logic          res,
  output logic          res_valid,
  output logic [RW-1:0] residue
`ifdef MODN_BITCOUNT_EN
  ,
  output logic [CNT_W-1:0] bit_count
`endif
);

  if (MODULUS < 2 || MODULUS > 255 || CNT_W < 1) begin : g_cfg_check
    $error("modn_serial_checker: MODULUS must be 2..255 and CNT_W >= 1");
  end

  logic [RW-1:0] residue_q, residue_d;
  logic [RW-1:0] weight_q, weight_d;
  bit_order_e    mode_q, mode_d;
  state_e        state_q, state_d;
  logic          res_q, res_d;

  logic [RW-1:0] step_r, step_w, step_r_next, step_w_next;
  bit_order_e    step_mode;

  modn_step #(
    .MODULUS (MODULUS)
  ) u_step (
    .r      (step_r),
    .w      (step_w),
    .b      (bit_in),
    .mode   (step_mode),
    .r_next (step_r_next),
    .w_next (step_w_next)
  );

  // When clear and bit_valid coincide, the step starts from the cleared
  // state with the freshly sampled mode, so the bit opens the new number.
  always_comb begin
    step_r    = clear ? '0 : residue_q;
    step_w    = clear ? RW'(1) : weight_q;
    step_mode = clear ? bit_order_e'(mode) : mode_q;

    residue_d = residue_q;
    weight_d  = weight_q;
    mode_d    = mode_q;
    state_d   = state_q;

    if (clear) begin
      residue_d = '0;
      weight_d  = RW'(1);
      mode_d    = bit_order_e'(mode);
      state_d   = IDLE;
    end
    if (bit_valid) begin
      residue_d = step_r_next;
      weight_d  = step_w_next;
      state_d   = ACCUM;
    end
    res_d = (residue_d == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      residue_q <= '0;
      weight_q  <= RW'(1);
      mode_q    <= MSB_FIRST;
      state_q   <= IDLE;
      res_q     <= 1'b1;
    end else begin
      residue_q <= residue_d;
      weight_q  <= weight_d;
      mode_q    <= mode_d;
      state_q   <= state_d;
      res_q     <= res_d;
    end
  end

  assign residue   = residue_q;
  assign res       = res_q;
  assign res_valid = (state_q == ACCUM);

`ifdef MODN_BITCOUNT_EN
  logic [CNT_W-1:0] count_q, count_d, count_base;

  always_comb begin
    count_base = clear ? '0 : count_q;
    count_d    = count_base;
    if (bit_valid && (count_base != '1)) begin
      count_d = count_base + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_count = count_q;
`endif

endmodule

// File: tb/tb_modn_serial_checker.sv
module tb_modn_serial_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, clear, mode, bit_in, bit_valid;

  logic       res3, res5, res7, res13;
  logic       rv3, rv5, rv7, rv13;
  logic [1:0] r3;
  logic [2:0] r5, r7;
  logic [3:0] r13;
`ifdef MODN_BITCOUNT_EN
  logic [3:0] bc3, bc5, bc7, bc13;
`endif

  int checks = 0;
  int errors = 0;

  int unsigned mods[4] = '{3, 5, 7, 13};
  logic [7:0]  resid_a[4];
  logic [3:0]  res_a, rv_a;

  assign resid_a[0] = {6'b0, r3};
  assign resid_a[1] = {5'b0, r5};
  assign resid_a[2] = {5'b0, r7};
  assign resid_a[3] = {4'b0, r13};
  assign res_a = {res13, res7, res5, res3};
  assign rv_a  = {rv13, rv7, rv5, rv3};
`ifdef MODN_BITCOUNT_EN
  logic [3:0] bc_a[4];
  assign bc_a[0] = bc3;
  assign bc_a[1] = bc5;
  assign bc_a[2] = bc7;
  assign bc_a[3] = bc13;
`endif

  modn_serial_checker #(.MODULUS(3), .CNT_W(4)) u3 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .res(res3), .res_valid(rv3), .residue(r3)
`ifdef MODN_BITCOUNT_EN
    , .bit_count(bc3)
`endif
  );
  modn_serial_checker #(.MODULUS(5), .CNT_W(4)) u5 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .res(res5), .res_valid(rv5), .residue(r5)
`ifdef MODN_BITCOUNT_EN
    , .bit_count(bc5)
`endif
  );
  modn_serial_checker #(.MODULUS(7), .CNT_W(4)) u7 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .res(res7), .res_valid(rv7), .residue(r7)
`ifdef MODN_BITCOUNT_EN
    , .bit_count(bc7)
`endif
  );
  modn_serial_checker #(.MODULUS(13), .CNT_W(4)) u13 (
    .clk(clk), .reset_n(reset_n), .clear(clear), .mode(mode), .bit_in(bit_in),
    .bit_valid(bit_valid), .res(res13), .res_valid(rv13), .residue(r13)
`ifdef MODN_BITCOUNT_EN
    , .bit_count(bc13)
`endif
  );

  // Reference model: the bits of the current number plus its bit order.
  bit q[$];
  bit mq;

  function automatic int unsigned model_residue(input int unsigned n);
    int unsigned v, pw;
    v  = 0;
    pw = 1;
    foreach (q[i]) begin
      if (!mq) begin
        v = (v * 2 + q[i]) % n;
      end else begin
        v  = (v + q[i] * pw) % n;
        pw = (pw * 2) % n;
      end
    end
    return v;
  endfunction

  function automatic int unsigned model_count();
    return (q.size() > 15) ? 15 : q.size();
  endfunction

  // Drive one cycle on the falling edge, apply it to the model at the
  // rising edge, and return 1 time unit later for sampling.
  task automatic cycle(input bit c, input bit m, input bit b, input bit v);
    @(negedge clk);
    clear = c; mode = m; bit_in = b; bit_valid = v;
    @(posedge clk);
    if (reset_n) begin
      if (c) begin
        q.delete();
        mq = m;
      end
      if (v) q.push_back(b);
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; mode = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    q.delete(); mq = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (resid_a[i] !== 8'd0) begin
        errors++; $display("FAIL reset_residue N=%0d got %0d exp 0", mods[i], resid_a[i]);
      end
      checks++;
      if (res_a[i] !== 1'b1) begin
        errors++; $display("FAIL reset_res N=%0d got %b exp 1", mods[i], res_a[i]);
      end
      checks++;
      if (rv_a[i] !== 1'b0) begin
        errors++; $display("FAIL reset_res_valid N=%0d got %b exp 0", mods[i], rv_a[i]);
      end
`ifdef MODN_BITCOUNT_EN
      checks++;
      if (bc_a[i] !== 4'd0) begin
        errors++; $display("FAIL reset_bit_count N=%0d got %0d exp 0", mods[i], bc_a[i]);
      end
`endif
    end
    reset_n = 1'b1;
  endtask

  task automatic test_msb_n3();
    int bits[7] = '{1, 1, 0, 0, 1, 1, 0};
    int expr[7] = '{1, 0, 0, 0, 1, 0, 0};
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (r3 !== 2'd0 || res3 !== 1'b1 || rv3 !== 1'b0) begin
      errors++; $display("FAIL msb3_clear got r=%0d res=%b rv=%b exp r=0 res=1 rv=0", r3, res3, rv3);
    end
    for (int k = 0; k < 7; k++) begin
      cycle(1'b0, 1'($urandom), 1'(bits[k]), 1'b1);
      checks++;
      if (r3 !== 2'(expr[k])) begin
        errors++; $display("FAIL msb3_residue bit%0d got %0d exp %0d", k, r3, expr[k]);
      end
      checks++;
      if (res3 !== (expr[k] == 0) || rv3 !== 1'b1) begin
        errors++; $display("FAIL msb3_res bit%0d got res=%b rv=%b exp res=%b rv=1", k, res3, rv3, expr[k] == 0);
      end
    end
  endtask

  task automatic test_lsb_n5();
    int bits[3] = '{1, 0, 1};
    int exp_l[3] = '{1, 1, 0};
    int exp_m[3] = '{1, 2, 0};
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'($urandom), 1'(bits[k]), 1'b1);
      checks++;
      if (r5 !== 3'(exp_l[k]) || res5 !== (exp_l[k] == 0)) begin
        errors++; $display("FAIL lsb5 bit%0d got r=%0d res=%b exp r=%0d res=%b", k, r5, res5, exp_l[k], exp_l[k] == 0);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'($urandom), 1'(bits[k]), 1'b1);
      checks++;
      if (r5 !== 3'(exp_m[k]) || res5 !== (exp_m[k] == 0)) begin
        errors++; $display("FAIL msb5 bit%0d got r=%0d res=%b exp r=%0d res=%b", k, r5, res5, exp_m[k], exp_m[k] == 0);
      end
    end
  endtask

  task automatic test_gaps_n7();
    int expr[3] = '{1, 3, 0};
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'($urandom), 1'b1, 1'b1);
      checks++;
      if (r7 !== 3'(expr[k])) begin
        errors++; $display("FAIL gap7_residue bit%0d got %0d exp %0d", k, r7, expr[k]);
      end
      if (k < 2) begin
        for (int g = 0; g < 3; g++) begin
          cycle(1'b0, 1'($urandom), 1'($urandom), 1'b0);
          checks++;
          if (r7 !== 3'(expr[k]) || rv7 !== 1'b1) begin
            errors++; $display("FAIL gap7_hold bit%0d gap%0d got r=%0d rv=%b exp r=%0d rv=1", k, g, r7, rv7, expr[k]);
          end
        end
      end
    end
    checks++;
    if (res7 !== 1'b1) begin
      errors++; $display("FAIL gap7_final_res got %b exp 1", res7);
    end
  endtask

  task automatic test_clear_with_bit();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (r3 !== 2'd2) begin
      errors++; $display("FAIL clrbit_pre got %0d exp 2", r3);
    end
    cycle(1'b1, 1'($urandom), 1'b1, 1'b1);
    checks++;
    if (r3 !== 2'd1 || res3 !== 1'b0 || rv3 !== 1'b1) begin
      errors++; $display("FAIL clrbit got r=%0d res=%b rv=%b exp r=1 res=0 rv=1", r3, res3, rv3);
    end
`ifdef MODN_BITCOUNT_EN
    checks++;
    if (bc3 !== 4'd1) begin
      errors++; $display("FAIL clrbit_count got %0d exp 1", bc3);
    end
`endif
  endtask

  task automatic test_async_reset();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (r3 !== 2'd2) begin
      errors++; $display("FAIL arst_pre got %0d exp 2", r3);
    end
    @(negedge clk);
    bit_valid = 1'b1; bit_in = 1'b1; clear = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (r3 !== 2'd0 || res3 !== 1'b1 || rv3 !== 1'b0) begin
      errors++; $display("FAIL arst_immediate got r=%0d res=%b rv=%b exp r=0 res=1 rv=0", r3, res3, rv3);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (resid_a[i] !== 8'd0 || res_a[i] !== 1'b1 || rv_a[i] !== 1'b0) begin
        errors++; $display("FAIL arst_discard N=%0d got r=%0d res=%b rv=%b exp r=0 res=1 rv=0",
                           mods[i], resid_a[i], res_a[i], rv_a[i]);
      end
    end
    @(negedge clk);
    bit_valid = 1'b0;
    reset_n = 1'b1;
    q.delete(); mq = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom_range(0, 15) == 0), 1'($urandom), 1'($urandom), ($urandom_range(0, 3) != 0));
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (resid_a[i] !== 8'(model_residue(mods[i]))) begin
          errors++; $display("FAIL rand_residue N=%0d cyc%0d got %0d exp %0d", mods[i], n, resid_a[i], model_residue(mods[i]));
        end
        checks++;
        if (res_a[i] !== (model_residue(mods[i]) == 0) || rv_a[i] !== (q.size() > 0)) begin
          errors++; $display("FAIL rand_flags N=%0d cyc%0d got res=%b rv=%b exp res=%b rv=%b",
                             mods[i], n, res_a[i], rv_a[i], model_residue(mods[i]) == 0, q.size() > 0);
        end
`ifdef MODN_BITCOUNT_EN
        checks++;
        if (bc_a[i] !== 4'(model_count())) begin
          errors++; $display("FAIL rand_count N=%0d cyc%0d got %0d exp %0d", mods[i], n, bc_a[i], model_count());
        end
`endif
      end
    end
  endtask

`ifdef MODN_BITCOUNT_EN
  task automatic test_bitcount();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b0, 1'($urandom), 1'b1);
      checks++;
      if (bc3 !== 4'(model_count())) begin
        errors++; $display("FAIL bitcount step%0d got %0d exp %0d", k, bc3, model_count());
      end
    end
    checks++;
    if (bc7 !== 4'd15) begin
      errors++; $display("FAIL bitcount_sat got %0d exp 15", bc7);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bc13 !== 4'd0) begin
      errors++; $display("FAIL bitcount_clear got %0d exp 0", bc13);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_msb_n3();
    test_lsb_n5();
    test_gaps_n7();
    test_clear_with_bit();
    test_async_reset();
    test_random();
`ifdef MODN_BITCOUNT_EN
    test_bitcount();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modn_serial_checker.md
Name: modn_serial_checker

Overview:
- Serial bit-stream divisibility detector for a parametrised modulus MODULUS.
- Accepts one bit per cycle under a valid qualifier, in MSB-first or LSB-first order, and keeps the running residue of the number received so far.
- Flags when the number received since the last clear is divisible by MODULUS.
- Generalised successor to the fixed divide-by-3 serial detector; used as a streaming front-end checker in the datapath lab designs.

Parameters:
MODULUS, 3, divisor N; legal range 2..255
RW, $clog2(MODULUS), residue width (derived, not overridden)
CNT_W, 8, bit-counter width (used only with MODN_BITCOUNT_EN)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
clear  input  1  synchronous start of a new number; latches mode
mode  input  1  0 = MSB-first, 1 = LSB-first; sampled only when clear=1
bit_in  input  1  serial data bit
bit_valid  input  1  bit_in is consumed this cycle when high
res  output  1  1 when the accumulated value mod MODULUS == 0
res_valid  output  1  1 once at least one bit has been accepted since clear/reset
residue  output  RW  current accumulated value mod MODULUS
bit_count  output  CNT_W  bits accepted since clear (only with MODN_BITCOUNT_EN)

Behaviour:
- Reset (reset_n low, asynchronous) values:
  - residue=0, weight=1, mode_q=0 (MSB-first)
  - res=1 (an empty number is 0, which is divisible); res_valid=0; bit_count=0
- All outputs are registered. Latency: a bit accepted at edge k is reflected in res/residue/res_valid immediately after edge k.
- States: IDLE (res_valid=0) and ACCUM (res_valid=1).
  - IDLE -> ACCUM on the first accepted bit.
  - ACCUM -> IDLE on clear without bit_valid.
- MSB-first update: r' = 2r + b, then subtract MODULUS once if the result >= MODULUS.
- LSB-first update:
  - r' = r + (b ? w : 0), then one conditional subtract.
  - w' = 2w, then one conditional subtract.
  - w starts at 1 after reset or clear.
- Width rule: all intermediates use RW+1 bits. A single conditional subtract is sufficient; no divider is inferred.
- bit_valid=0: every register holds its value. Gaps between bits are legal.
- clear=1 with bit_valid=0:
  - residue=0, weight=1, res=1, res_valid=0, bit_count=0
  - mode_q <= mode
- clear=1 with bit_valid=1 in the same cycle:
  - clear takes priority.
  - bit_in becomes the first bit of the new number, using the newly sampled mode.
  - Result: residue = bit_in mod MODULUS, res_valid=1.
- A change on mode while clear=0 is ignored.
- res is always equal to (residue == 0) after every edge.
- reset_n asserted mid-stream returns all outputs to their reset values asynchronously. Bits presented during reset are discarded.

Optional Feature:
- Macro: MODN_BITCOUNT_EN.
- Defined:
  - bit_count port exists.
  - Increments on each accepted bit and saturates at 2^CNT_W-1; it does not wrap.
  - Cleared by clear (set to 1 if clear and bit_valid coincide) and by reset.
- Undefined:
  - bit_count port and counter are absent.
  - All other behaviour is unchanged.

Decomposition:
- Package modn_pkg holds:
  - the bit-order typedef (MSB_FIRST=0, LSB_FIRST=1)
  - the IDLE/ACCUM state typedef
  - a constant function for the residue width
- One sub-module, modn_step: purely combinational. Takes (r, w, b, mode) and returns (r_next, w_next). It is instantiated once and unit-testable on its own.

Test Plan:
- N=3, MSB-first, bits 1,1,0,0,1,1,0 (values 1,3,6,12,25,51,102) -> residue 1,0,0,0,1,0,0; res 0,1,1,1,0,1,1; res_valid=1 from the first bit.
- N=5, LSB-first, bits 1,0,1 (value 5) -> residue 1,1,0; res 0,0,1. Then clear with mode=0 and MSB-first bits 1,0,1 -> residue 1,2,0.
- N=7, MSB-first, bits 1,1,1 with bit_valid dropped for 3 cycles between each bit -> residue 1,3,0 and held steady during the gaps; final res=1.
- N=3, clear and bit_valid together with bit_in=1 after residue=2 -> next residue=1, res=0, res_valid=1, bit_count=1.
- N=3, reset_n pulsed low mid-stream (residue=2) -> residue=0, res=1, res_valid=0 immediately, without waiting for a clock edge.
- MODN_BITCOUNT_EN, CNT_W=4, 20 consecutive accepted bits -> bit_count reaches 15 and holds; clear returns it to 0.
